alu_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_seq_perf.sv | 31 +++
 rtl/alu_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU issue sequencer: vector geometry, opcodes and FSM states.
package alu_seq_pkg;

  localparam int LANES     = 16;
  localparam int LANE_W    = 16;
  localparam int DATA_W    = LANES * LANE_W;
  localparam int RED_STEPS = $clog2(LANES);
  localparam int STEP_W    = (RED_STEPS > 1) ? $clog2(RED_STEPS) : 1;
  localparam int SHIFT_W   = $clog2(DATA_W) + 1;
  localparam int PERF_W    = 32;

  localparam logic [3:0] VADD = 4'h0;
  localparam logic [3:0] VDOT = 4'h1;
  localparam logic [3:0] SMUL = 4'h2;
  localparam logic [3:0] SST  = 4'h3;
  localparam logic [3:0] VLD  = 4'h4;
  localparam logic [3:0] VST  = 4'h5;
  localparam logic [3:0] SLL  = 4'h6;
  localparam logic [3:0] SLH  = 4'h7;
  localparam logic [3:0] J    = 4'h8;
  localparam logic [3:0] NOP  = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_seq_perf.sv
// Performance counters for the ALU sequencer: completed instructions and busy cycles.
// Only instantiated when ALU_SEQ_PERF_EN is defined.
module alu_seq_perf
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_out_hs,
  input  logic              i_busy,
  output logic [PERF_W-1:0] o_instr_cnt,
  output logic [PERF_W-1:0] o_busy_cnt
);

  logic [PERF_W-1:0] r_instr_cnt;
  logic [PERF_W-1:0] r_busy_cnt;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
      r_busy_cnt  <= '0;
    end else begin
      if (i_out_hs) r_instr_cnt <= r_instr_cnt + PERF_W'(1);
      if (i_busy)   r_busy_cnt  <= r_busy_cnt + PERF_W'(1);
    end
  end

  assign o_instr_cnt = r_instr_cnt;
  assign o_busy_cnt  = r_busy_cnt;

endmodule

// File: rtl/alu_sequencer.sv
// Issue/sequencing controller in front of the combinational vector ALU; VDOT runs as a
// multiply pass plus a VADD lane-reduction tree. Optional perf counters: ALU_SEQ_PERF_EN.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [DATA_W-1:0] in_op_1,
  input  logic [DATA_W-1:0] in_op_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_op_1,
  output logic [DATA_W-1:0] alu_op_2,
  input  logic [DATA_W-1:0] alu_result
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_instr_cnt,
  output logic [PERF_W-1:0] perf_busy_cnt
`endif
);

  seq_state_e          r_state;
  seq_state_e          w_next;
  logic [3:0]          r_opcode;
  logic [DATA_W-1:0]   r_op1;
  logic [DATA_W-1:0]   r_op2;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_result;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [SHIFT_W-1:0]  w_shift;
  logic                w_in_hs;
  logic                w_out_hs;
  logic                w_last_step;

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign out_result  = r_result;
  assign w_in_hs     = in_valid & in_ready;
  assign w_out_hs    = out_valid & out_ready;
  assign w_last_step = (r_step_cnt == STEP_W'(RED_STEPS - 1));
  // Each reduction step folds the upper half of the still-live lanes onto the lower half.
  assign w_shift     = SHIFT_W'(DATA_W / 2) >> r_step_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    alu_opcode = NOP;
    alu_op_1   = '0;
    alu_op_2   = '0;
    case (r_state)
      IDLE: begin
        if (w_in_hs) w_next = EXEC;
      end
      EXEC: begin
        alu_opcode = r_opcode;
        alu_op_1   = r_op1;
        alu_op_2   = r_op2;
        w_next     = (r_opcode == VDOT) ? REDUCE : DONE;
      end
      REDUCE: begin
        alu_opcode = VADD;
        alu_op_1   = r_acc;
        alu_op_2   = r_acc >> w_shift;
        if (w_last_step) w_next = DONE;
      end
      DONE: begin
        if (w_out_hs) w_next = IDLE;
      end
    endcase
  end

  // The result register is only written on the way into DONE, so backpressure holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode   <= 4'h0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_step_cnt <= '0;
    end else begin
      if (w_in_hs) begin
        r_opcode <= in_opcode;
        r_op1    <= in_op_1;
        r_op2    <= in_op_2;
      end
      case (r_state)
        EXEC: begin
          r_acc      <= alu_result;
          r_step_cnt <= '0;
          if (r_opcode != VDOT) r_result <= alu_result;
        end
        REDUCE: begin
          r_acc      <= alu_result;
          r_step_cnt <= r_step_cnt + STEP_W'(1);
          if (w_last_step) r_result <= DATA_W'(alu_result[LANE_W-1:0]);
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  alu_seq_perf u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_out_hs    (w_out_hs),
    .i_busy      (r_state != IDLE),
    .o_instr_cnt (perf_instr_cnt),
    .o_busy_cnt  (perf_busy_cnt)
  );
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: plays a half-float vector ALU and compares every
// cycle against a transaction-level model, plus directed literal checks.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int W = DATA_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [W-1:0]  in_op_1;
  logic [W-1:0]  in_op_2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [3:0]    alu_opcode;
  logic [W-1:0]  alu_op_1;
  logic [W-1:0]  alu_op_2;
  logic [W-1:0]  alu_result;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0]   perf_instr_cnt;
  logic [31:0]   perf_busy_cnt;
`endif

  int checkCnt = 0;
  int passCnt  = 0;
  int cycleCnt = 0;
  int acceptCycle = 0;
  bit randOut = 0;
  bit recOn = 0;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_op_1(in_op_1), .in_op_2(in_op_2),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .alu_opcode(alu_opcode), .alu_op_1(alu_op_1), .alu_op_2(alu_op_2),
    .alu_result(alu_result)
`ifdef ALU_SEQ_PERF_EN
    , .perf_instr_cnt(perf_instr_cnt), .perf_busy_cnt(perf_busy_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkEq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Half-float helpers, exact for the small integer values the bench uses.
  function automatic real h2r(input logic [15:0] h);
    int e; int n; real v;
    e = int'(h[14:10]);
    v = (e == 0) ? real'(h[9:0]) : 1024.0 + real'(h[9:0]);
    n = (e == 0) ? -24 : e - 25;
    while (n > 0) begin v = v * 2.0; n--; end
    while (n < 0) begin v = v / 2.0; n++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real m; int e; int man; logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    man = $rtoi((m - 1.0) * 1024.0 + 0.5);
    if (man == 1024) begin man = 0; e++; end
    return {s, e[4:0], man[9:0]};
  endfunction

  function automatic logic [W-1:0] aluModel(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (op)
      VADD: for (int i = 0; i < LANES; i++)
              r[i*LANE_W +: LANE_W] = r2h(h2r(a[i*LANE_W +: LANE_W]) + h2r(b[i*LANE_W +: LANE_W]));
      VDOT: for (int i = 0; i < LANES; i++)
              r[i*LANE_W +: LANE_W] = r2h(h2r(a[i*LANE_W +: LANE_W]) * h2r(b[i*LANE_W +: LANE_W]));
      NOP:  r = '0;
      default: r = a + b;
    endcase
    return r;
  endfunction

  always_comb alu_result = aluModel(alu_opcode, alu_op_1, alu_op_2);

  // Transaction model: busy flag, cycles since accept, expected result and latency.
  bit           mBusy = 0;
  int           mCyc = 0;
  int           mLat = 2;
  logic [3:0]   mOp;
  logic [W-1:0] mA, mB, mRes;
  logic [W-1:0] mAcc [0:RED_STEPS];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy = 0;
    end else if (!mBusy) begin
      if (in_valid) begin
        mBusy = 1; mCyc = 1;
        mOp = in_opcode; mA = in_op_1; mB = in_op_2;
        if (mOp == VDOT) begin
          mAcc[0] = aluModel(VDOT, mA, mB);
          for (int s = 0; s < RED_STEPS; s++)
            mAcc[s+1] = aluModel(VADD, mAcc[s], mAcc[s] >> ((W / 2) >> s));
          mRes = W'(mAcc[RED_STEPS][LANE_W-1:0]);
          mLat = 2 + RED_STEPS;
        end else begin
          mRes = aluModel(mOp, mA, mB);
          mLat = 2;
        end
      end
    end else if (mCyc >= mLat && out_ready) begin
      mBusy = 0;
    end else begin
      mCyc++;
    end
  end

  always @(negedge clk) begin
    logic [3:0]   eOp;
    logic [W-1:0] eA, eB;
    bit           eValid;
    eOp = NOP; eA = '0; eB = '0;
    if (mBusy && mCyc == 1) begin
      eOp = mOp; eA = mA; eB = mB;
    end else if (mBusy && mOp == VDOT && mCyc >= 2 && mCyc < 2 + RED_STEPS) begin
      eOp = VADD; eA = mAcc[mCyc-2]; eB = mAcc[mCyc-2] >> ((W / 2) >> (mCyc - 2));
    end
    eValid = mBusy && (mCyc >= mLat);
    checkEq("cyc in_ready", W'(in_ready), W'(!mBusy));
    checkEq("cyc out_valid", W'(out_valid), W'(eValid));
    if (eValid) checkEq("cyc out_result", out_result, mRes);
    checkEq("cyc alu_opcode", W'(alu_opcode), W'(eOp));
    checkEq("cyc alu_op_1", alu_op_1, eA);
    checkEq("cyc alu_op_2", alu_op_2, eB);
  end

  // Output handshake and reduction-pass recorders for directed checks.
  logic [W-1:0] resQ[$];
  int           hsQ[$];
  logic [W-1:0] redA[$];
  logic [W-1:0] redB[$];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      resQ.push_back(out_result);
      hsQ.push_back(cycleCnt + 1);
    end
    if (recOn && alu_opcode == VADD) begin
      redA.push_back(alu_op_1);
      redB.push_back(alu_op_2);
    end
  end

  always @(posedge clk) begin
    if (randOut) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    in_valid = 1'b1; in_opcode = op; in_op_1 = a; in_op_2 = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checkEq("accept timeout", W'(0), W'(1));
    end else begin
      @(posedge clk); #1;
      acceptCycle = cycleCnt;
    end
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] exp, input int lat);
    int n;
    logic [W-1:0] res;
    int hs;
    n = 0;
    while (resQ.size() == 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (resQ.size() == 0) begin
      checkEq({name, " timeout"}, W'(0), W'(1));
    end else begin
      res = resQ.pop_front();
      hs  = hsQ.pop_front();
      checkEq(name, res, exp);
      if (lat > 0) checkEq({name, " latency"}, W'(hs - acceptCycle), W'(lat));
    end
  endtask

  function automatic logic [W-1:0] splat(input logic [15:0] h);
    logic [W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = h;
    return v;
  endfunction

  function automatic logic [W-1:0] randVec(input bit fp);
    logic [W-1:0] v;
    for (int i = 0; i < LANES; i++)
      v[i*LANE_W +: LANE_W] = fp ? r2h(real'($urandom_range(0, 7))) : 16'($urandom);
    return v;
  endfunction

  initial begin
    int a1, a2, n;
    int shiftLit[4];
    logic [3:0] op;
    shiftLit = '{128, 64, 32, 16};
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = 4'h0; in_op_1 = '0; in_op_2 = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checkEq("reset in_ready", W'(in_ready), W'(1));
    checkEq("reset out_valid", W'(out_valid), W'(0));
    checkEq("reset out_result", out_result, '0);
    checkEq("reset alu_opcode", W'(alu_opcode), W'(4'hF));
    checkEq("reset alu_op_1", alu_op_1, '0);

    applyStimulus(VADD, splat(16'h3C00), splat(16'h3C00));
    checkOutput("vadd result", splat(16'h4000), 2);

    recOn = 1;
    applyStimulus(VDOT, splat(16'h3C00), splat(16'h4000));
    checkOutput("vdot result", W'(16'h5000), 6);
    recOn = 0;
    checkEq("vdot pass count", W'(redA.size()), W'(4));
    for (int i = 0; i < 4 && i < redA.size(); i++)
      checkEq($sformatf("vdot shift %0d", shiftLit[i]), redB[i], redA[i] >> shiftLit[i]);

`ifdef ALU_SEQ_PERF_EN
    checkEq("perf_instr_cnt", W'(perf_instr_cnt), W'(2));
    checkEq("perf_busy_cnt", W'(perf_busy_cnt), W'(8));
`endif

    out_ready = 1'b0;
    applyStimulus(SST, W'(16'h10), W'(16'h20));
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      checkEq("bp out_valid", W'(out_valid), W'(1));
      checkEq("bp out_result", out_result, W'(16'h30));
      checkEq("bp in_ready", W'(in_ready), W'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    checkOutput("bp release", W'(16'h30), 0);

    applyStimulus(NOP, splat(16'h1234), splat(16'h5678));
    a1 = acceptCycle;
    applyStimulus(J, W'(4'h4), W'(4'h8));
    a2 = acceptCycle;
    checkEq("b2b interval", W'(a2 - a1), W'(3));
    checkOutput("b2b nop", '0, 0);
    checkOutput("b2b j", W'(4'hC), 2);

    applyStimulus(VDOT, splat(16'h3C00), splat(16'h4000));
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkEq("abort out_valid", W'(out_valid), W'(0));
    checkEq("abort alu_opcode", W'(alu_opcode), W'(4'hF));
    checkEq("abort in_ready", W'(in_ready), W'(1));
    checkEq("abort alu_op_1", alu_op_1, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checkEq("abort no output", W'(resQ.size()), W'(0));
    applyStimulus(VADD, splat(16'h4000), splat(16'h3C00));
    checkOutput("post-reset vadd", splat(16'h4200), 2);

    randOut = 1;
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op = 4'($urandom_range(0, 15));
      applyStimulus(op, randVec(op == VADD || op == VDOT), randVec(op == VADD || op == VDOT));
    end
    n = 0;
    while (mBusy && n < 200) begin @(posedge clk); #1; n++; end
    checkEq("drain idle", W'(mBusy), W'(0));
    randOut = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
